// File: rtl/seg_data_reg_pkg.sv
// seg_pkg: shared constants and types for the seg_data_reg display data register.
// Contents: default register addresses, ctrl bit indices, FSM state enum,
//           BCD range limit, overflow pattern, iteration count, byte-strobe merge helper.
package seg_pkg;

   localparam logic [31:0] ADDR_DISP_DEF = 32'hFFFF_F000;
   localparam logic [31:0] ADDR_CTRL_DEF = 32'hFFFF_F004;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_BCD = 1;
   localparam int CTRL_IMM = 2;
   localparam logic [2:0] CTRL_RST = 3'b001;

   localparam logic [31:0] BCD_MAX  = 32'd99_999_999;
   localparam logic [31:0] BCD_OVF  = 32'hEEEE_EEEE;
   localparam int          BCD_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   // Replace the bytes of old_val that are enabled in strb with the matching bytes of new_val.
   function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/seg_data_reg_if.sv
// seg_data_reg_if: CPU data bus bundle for the display data register.
// master: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb out; bus_ready, bus_rdata in.
// slave : mirror of master; bus_rdata is combinational and zero-wait.
interface seg_data_reg_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
                   input  bus_ready, bus_rdata);
   modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
                   output bus_ready, bus_rdata);
endinterface

// File: rtl/seg_data_reg_bcd_conv.sv
// bcd_conv: iterative double-dabble, 32-bit binary in, 8-digit packed BCD out.
// Ports: clk, rst (sync, active-high), start_i/bin_i load, busy_o while shifting,
//        done_o pulses in the last shift cycle with bcd_o already valid (combinational).
// Latency: start at edge N, 32 shifts on edges N+1..N+32; inputs > 99_999_999 yield 32'hEEEE_EEEE.
module bcd_conv
   import seg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] bin_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] bcd_o
);

   // {bcd digits, binary remainder}; the binary shifts out into the digits
   logic [63:0] sh_q, sh_d, adj, shifted;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        ovf_q, ovf_d;
   logic        last;

   always_comb begin
      adj = sh_q;
      for (int i = 0; i < 8; i++) begin
         if (sh_q[32 + 4*i +: 4] >= 4'd5) adj[32 + 4*i +: 4] = sh_q[32 + 4*i +: 4] + 4'd3;
      end
      shifted = {adj[62:0], 1'b0};
   end

   assign last = busy_q && (cnt_q == 5'(BCD_ITER - 1));

   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      ovf_d  = ovf_q;
      if (start_i) begin
         sh_d   = {32'h0, bin_i};
         cnt_d  = 5'd0;
         busy_d = 1'b1;
         // range checked up front; the full shift sequence still runs for fixed latency
         ovf_d  = (bin_i > BCD_MAX);
      end else if (busy_q) begin
         sh_d  = shifted;
         cnt_d = cnt_q + 5'd1;
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q   <= 64'h0;
         cnt_q  <= 5'd0;
         busy_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         ovf_q  <= ovf_d;
      end
   end

   // bcd_o is taken from the last shift's next value so the caller can capture it on that same edge
   assign busy_o = busy_q;
   assign done_o = last;
   assign bcd_o  = ovf_q ? BCD_OVF : shifted[63:32];

endmodule

// File: rtl/seg_data_reg.sv
// seg_data_reg: display data register between CPU bus and 8-digit scanner; shadow commits on frame_tick or IMM.
// Ports: clk, rst (sync, active-high), bus (seg_data_reg_if.slave), frame_tick in, data[31:0] out.
// Latency: hex write at N -> data after edge N+1 (IMM); BCD adds 32 cycles. Backpressure: bus_ready low
// only in CONV for ADDR_DISP/ADDR_CTRL accesses. Optional macro SEG_BCD_EN builds the BCD converter.
module seg_data_reg
   import seg_pkg::*;
#(
   parameter logic [31:0] ADDR_DISP = ADDR_DISP_DEF,
   parameter logic [31:0] ADDR_CTRL = ADDR_CTRL_DEF,
   parameter logic [31:0] RST_VAL   = 32'h0000_0000
)(
   input  logic                clk,
   input  logic                rst,
   seg_data_reg_if.slave       bus,
   input  logic                frame_tick,
   output logic [31:0]         data
);

`ifdef SEG_BCD_EN
   localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
   localparam logic [2:0] CTRL_WMASK = 3'b101;
`endif

   state_e      state_q, state_d;
   logic [31:0] raw_q, raw_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] commit_q, commit_d;

   logic        hit_disp, hit_ctrl, wr_acc, disp_wr, ctrl_wr;
   logic [31:0] merged;

   assign hit_disp = (bus.bus_addr == ADDR_DISP);
   assign hit_ctrl = (bus.bus_addr == ADDR_CTRL);

`ifdef SEG_BCD_EN
   logic        conv_start, conv_busy, conv_done;
   logic [31:0] conv_res;

   assign bus.bus_ready = !((state_q == ST_CONV) && bus.bus_req && (hit_disp || hit_ctrl));

   bcd_conv u_bcd_conv (
      .clk     (clk),
      .rst     (rst),
      .start_i (conv_start),
      .bin_i   (merged),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .bcd_o   (conv_res)
   );
`else
   assign bus.bus_ready = 1'b1;
`endif

   assign wr_acc  = bus.bus_req && bus.bus_we && bus.bus_ready;
   assign disp_wr = wr_acc && hit_disp;
   assign ctrl_wr = wr_acc && hit_ctrl;
   assign merged  = merge_strb(raw_q, bus.bus_wdata, bus.bus_wstrb);

   always_comb begin
      state_d  = state_q;
      raw_d    = raw_q;
      ctrl_d   = ctrl_q;
      shadow_d = shadow_q;
      commit_d = commit_q;
`ifdef SEG_BCD_EN
      conv_start = 1'b0;
`endif

      if (disp_wr) raw_d = merged;
      if (ctrl_wr && bus.bus_wstrb[0]) ctrl_d = bus.bus_wdata[2:0] & CTRL_WMASK;

      case (state_q)
         ST_IDLE: ;
`ifdef SEG_BCD_EN
         ST_CONV: begin
            if (conv_done) begin
               shadow_d = conv_res;
               state_d  = ST_PEND;
            end else if (!conv_busy) begin
               // defensive: converter idle without a done pulse, nothing left to wait for
               state_d = ST_IDLE;
            end
         end
`endif
         ST_PEND: begin
            if (frame_tick || ctrl_q[CTRL_IMM]) begin
               commit_d = shadow_q;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A display write (only possible in IDLE or PEND) overrides the state transition above.
      // The commit above still uses the old shadow, so a write racing a frame_tick loses nothing.
      if (disp_wr) begin
`ifdef SEG_BCD_EN
         if (ctrl_q[CTRL_BCD]) begin
            conv_start = 1'b1;
            state_d    = ST_CONV;
         end else begin
            shadow_d = merged;
            state_d  = ST_PEND;
         end
`else
         shadow_d = merged;
         state_d  = ST_PEND;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         raw_q    <= RST_VAL;
         ctrl_q   <= CTRL_RST;
         shadow_q <= RST_VAL;
         commit_q <= RST_VAL;
      end else begin
         state_q  <= state_d;
         raw_q    <= raw_d;
         ctrl_q   <= ctrl_d;
         shadow_q <= shadow_d;
         commit_q <= commit_d;
      end
   end

   always_comb begin
      bus.bus_rdata = 32'h0;
      if (hit_disp)      bus.bus_rdata = raw_q;
      else if (hit_ctrl) bus.bus_rdata = {28'h0, (state_q != ST_IDLE), ctrl_q};
   end

   assign data = ctrl_q[CTRL_EN] ? commit_q : 32'h0;

endmodule

// File: tb/tb_seg_data_reg.sv
// tb_seg_data_reg: directed self-checking bench for seg_data_reg.
// Inputs change 1 time unit after the rising edge; outputs are sampled in the same settled window.
// BCD scenarios are included when SEG_BCD_EN is defined.
module tb_seg_data_reg;

   localparam logic [31:0] A_DISP  = 32'hFFFF_F000;
   localparam logic [31:0] A_CTRL  = 32'hFFFF_F004;
   localparam logic [31:0] A_UNMAP = 32'hFFFF_F008;

   logic        clk;
   logic        rst;
   logic        frame_tick;
   logic [31:0] data;

   int n_cmp = 0;
   int n_err = 0;

   seg_data_reg_if bus_if ();

   seg_data_reg dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if.slave),
      .frame_tick (frame_tick),
      .data       (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic tk);
      int guard = 0;
      bus_if.bus_req   = 1'b1;
      bus_if.bus_we    = 1'b1;
      bus_if.bus_addr  = a;
      bus_if.bus_wdata = d;
      bus_if.bus_wstrb = s;
      frame_tick       = tk;
      #1;
      while (bus_if.bus_ready !== 1'b1 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         $display("FAIL write_timeout: addr %h still not ready after %0d cycles, required ready", a, guard);
         n_err++;
         n_cmp++;
      end
      @(posedge clk); #1;
      bus_if.bus_req = 1'b0;
      bus_if.bus_we  = 1'b0;
      frame_tick     = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] rd, output logic rdy);
      bus_if.bus_req  = 1'b1;
      bus_if.bus_we   = 1'b0;
      bus_if.bus_addr = a;
      #1;
      rd  = bus_if.bus_rdata;
      rdy = bus_if.bus_ready;
      @(posedge clk); #1;
      bus_if.bus_req = 1'b0;
   endtask

   task automatic tick_cycle();
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        rdy;
      pulse_reset();
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h1) begin $display("FAIL reset_ctrl: got %h, required %h", rd, 32'h1); n_err++; end
      n_cmp++;
      if (rdy !== 1'b1) begin $display("FAIL reset_ready: got %b, required 1", rdy); n_err++; end
      n_cmp++;
      do_read(A_DISP, rd, rdy);
      if (rd !== 32'h0) begin $display("FAIL reset_disp: got %h, required %h", rd, 32'h0); n_err++; end
      n_cmp++;
      if (data !== 32'h0) begin $display("FAIL reset_data: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
   endtask

   task automatic test_hex_imm();
      logic [31:0] rd;
      logic        rdy;
      do_write(A_CTRL, 32'h5, 4'b0001, 1'b0);
      do_write(A_DISP, 32'h1234_5678, 4'b1111, 1'b0);
      if (data !== 32'h0) begin $display("FAIL hex_imm_early: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
      @(posedge clk); #1;
      if (data !== 32'h1234_5678) begin $display("FAIL hex_imm_data: got %h, required %h", data, 32'h1234_5678); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h5) begin $display("FAIL hex_imm_ctrl: got %h, required %h", rd, 32'h5); n_err++; end
      n_cmp++;
   endtask

   task automatic test_strb_pend();
      logic [31:0] rd;
      logic        rdy;
      do_write(A_CTRL, 32'h1, 4'b0001, 1'b0);
      do_write(A_DISP, 32'h0000_AB00, 4'b0010, 1'b0);
      do_read(A_DISP, rd, rdy);
      if (rd !== 32'h1234_AB78) begin $display("FAIL strb_raw: got %h, required %h", rd, 32'h1234_AB78); n_err++; end
      n_cmp++;
      repeat (3) @(posedge clk);
      #1;
      if (data !== 32'h1234_5678) begin $display("FAIL strb_hold: got %h, required %h", data, 32'h1234_5678); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h9) begin $display("FAIL strb_pending: got %h, required %h", rd, 32'h9); n_err++; end
      n_cmp++;
      tick_cycle();
      if (data !== 32'h1234_AB78) begin $display("FAIL strb_commit: got %h, required %h", data, 32'h1234_AB78); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h1) begin $display("FAIL strb_idle: got %h, required %h", rd, 32'h1); n_err++; end
      n_cmp++;
   endtask

   task automatic test_race();
      logic [31:0] rd;
      logic        rdy;
      do_write(A_DISP, 32'h1111_1111, 4'b1111, 1'b0);
      if (data !== 32'h1234_AB78) begin $display("FAIL race_hold: got %h, required %h", data, 32'h1234_AB78); n_err++; end
      n_cmp++;
      do_write(A_DISP, 32'h2222_2222, 4'b1111, 1'b1);
      if (data !== 32'h1111_1111) begin $display("FAIL race_old_commit: got %h, required %h", data, 32'h1111_1111); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h9) begin $display("FAIL race_pending: got %h, required %h", rd, 32'h9); n_err++; end
      n_cmp++;
      tick_cycle();
      if (data !== 32'h2222_2222) begin $display("FAIL race_new_commit: got %h, required %h", data, 32'h2222_2222); n_err++; end
      n_cmp++;
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      logic        rdy;
      do_write(A_UNMAP, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      do_read(A_UNMAP, rd, rdy);
      if (rd !== 32'h0) begin $display("FAIL unmap_rdata: got %h, required %h", rd, 32'h0); n_err++; end
      n_cmp++;
      if (rdy !== 1'b1) begin $display("FAIL unmap_ready: got %b, required 1", rdy); n_err++; end
      n_cmp++;
      do_read(A_DISP, rd, rdy);
      if (rd !== 32'h2222_2222) begin $display("FAIL unmap_raw: got %h, required %h", rd, 32'h2222_2222); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h1) begin $display("FAIL unmap_ctrl: got %h, required %h", rd, 32'h1); n_err++; end
      n_cmp++;
   endtask

   task automatic test_ctrl_fields();
      logic [31:0] rd;
      logic        rdy;
      logic [31:0] exp_bcd;
`ifdef SEG_BCD_EN
      exp_bcd = 32'h3;
`else
      exp_bcd = 32'h1;
`endif
      do_write(A_CTRL, 32'h0000_0700, 4'b0010, 1'b0);
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h1) begin $display("FAIL ctrl_strb: got %h, required %h", rd, 32'h1); n_err++; end
      n_cmp++;
      do_write(A_CTRL, 32'hFFFF_FFF3, 4'b0001, 1'b0);
      do_read(A_CTRL, rd, rdy);
      if (rd !== exp_bcd) begin $display("FAIL ctrl_bcd_bit: got %h, required %h", rd, exp_bcd); n_err++; end
      n_cmp++;
      do_write(A_CTRL, 32'h1, 4'b0001, 1'b0);
   endtask

   task automatic test_enable();
      logic [31:0] rd;
      logic        rdy;
      do_write(A_CTRL, 32'h0, 4'b0001, 1'b0);
      if (data !== 32'h0) begin $display("FAIL en_off: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
      do_write(A_DISP, 32'h3333_3333, 4'b1111, 1'b0);
      tick_cycle();
      if (data !== 32'h0) begin $display("FAIL en_off_commit: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h0) begin $display("FAIL en_off_ctrl: got %h, required %h", rd, 32'h0); n_err++; end
      n_cmp++;
      do_write(A_CTRL, 32'h1, 4'b0001, 1'b0);
      if (data !== 32'h3333_3333) begin $display("FAIL en_on: got %h, required %h", data, 32'h3333_3333); n_err++; end
      n_cmp++;
   endtask

   task automatic test_reset_pend();
      logic [31:0] rd;
      logic        rdy;
      do_write(A_DISP, 32'h4444_4444, 4'b1111, 1'b0);
      pulse_reset();
      if (data !== 32'h0) begin $display("FAIL rstp_data: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
      do_read(A_DISP, rd, rdy);
      if (rd !== 32'h0) begin $display("FAIL rstp_raw: got %h, required %h", rd, 32'h0); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rd !== 32'h1) begin $display("FAIL rstp_ctrl: got %h, required %h", rd, 32'h1); n_err++; end
      n_cmp++;
      tick_cycle();
      if (data !== 32'h0) begin $display("FAIL rstp_no_commit: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
   endtask

`ifdef SEG_BCD_EN
   task automatic probe_conv(output int lows);
      lows = 0;
      bus_if.bus_req  = 1'b1;
      bus_if.bus_we   = 1'b0;
      bus_if.bus_addr = A_CTRL;
      #1;
      while (bus_if.bus_ready !== 1'b1 && lows < 100) begin
         lows++;
         @(posedge clk); #1;
      end
      bus_if.bus_req = 1'b0;
   endtask

   task automatic bcd_case(input logic [31:0] bin, input logic [31:0] exp, input logic [31:0] prev);
      int lows;
      do_write(A_DISP, bin, 4'b1111, 1'b0);
      probe_conv(lows);
      if (lows != 32) begin $display("FAIL bcd_busy_cycles: got %0d, required 32 (in %h)", lows, bin); n_err++; end
      n_cmp++;
      if (data !== prev) begin $display("FAIL bcd_early: got %h, required %h", data, prev); n_err++; end
      n_cmp++;
      @(posedge clk); #1;
      if (data !== exp) begin $display("FAIL bcd_result: got %h, required %h (in %h)", data, exp, bin); n_err++; end
      n_cmp++;
   endtask

   task automatic test_bcd();
      do_write(A_CTRL, 32'h7, 4'b0001, 1'b0);
      bcd_case(32'd12_345_678,  32'h1234_5678, 32'h0);
      bcd_case(32'd99_999_999,  32'h9999_9999, 32'h1234_5678);
      bcd_case(32'd100_000_000, 32'hEEEE_EEEE, 32'h9999_9999);
   endtask

   task automatic test_reset_conv();
      logic [31:0] rd;
      logic        rdy;
      do_write(A_DISP, 32'd42, 4'b1111, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      pulse_reset();
      if (data !== 32'h0) begin $display("FAIL rstc_data: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
      do_read(A_CTRL, rd, rdy);
      if (rdy !== 1'b1) begin $display("FAIL rstc_ready: got %b, required 1", rdy); n_err++; end
      n_cmp++;
      if (rd !== 32'h1) begin $display("FAIL rstc_ctrl: got %h, required %h", rd, 32'h1); n_err++; end
      n_cmp++;
      repeat (40) @(posedge clk);
      #1;
      tick_cycle();
      if (data !== 32'h0) begin $display("FAIL rstc_no_commit: got %h, required %h", data, 32'h0); n_err++; end
      n_cmp++;
   endtask
`endif

   initial begin
      rst              = 1'b1;
      frame_tick       = 1'b0;
      bus_if.bus_req   = 1'b0;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = 32'h0;
      bus_if.bus_wdata = 32'h0;
      bus_if.bus_wstrb = 4'h0;
      @(posedge clk); #1;

      test_reset();
      test_hex_imm();
      test_strb_pend();
      test_race();
      test_unmapped();
      test_ctrl_fields();
      test_enable();
      test_reset_pend();
`ifdef SEG_BCD_EN
      test_bcd();
      test_reset_conv();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg_data_reg.md
# seg_data_reg

Memory-mapped display data register that sits between the CPU data bus and the 8-digit seven-segment scanner. It accepts byte-strobed CPU stores, optionally converts the stored binary value to 8-digit BCD, and holds the result in a shadow register. The shadow is committed to the scanner's 32-bit `data` input only on a frame boundary, so a digit scan never shows a half-updated value.

## Interface
Parameters:
- `ADDR_DISP`, 32'hFFFF_F000, address of the display value register.
- `ADDR_CTRL`, 32'hFFFF_F004, address of the control register.
- `RST_VAL`, 32'h0000_0000, reset value of the raw, shadow and committed registers.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `bus_req`  in  1  bus access request.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  32  byte address.
- `bus_wdata`  in  32  write data.
- `bus_wstrb`  in  4  byte enables; bit i enables `bus_wdata[8i+7:8i]`.
- `bus_ready`  out  1  access accepted this cycle.
- `bus_rdata`  out  32  read data, valid when `bus_req & bus_ready & ~bus_we`.
- `frame_tick`  in  1  one-cycle pulse from the scanner when digit 0 is re-selected.
- `data`  out  32  nibble-per-digit value to the scanner; digit 0 is `data[3:0]`.

## Operation
- **Registers:**
  - `raw`: the CPU-visible value.
  - `ctrl`: bit0 EN, bit1 BCD, bit2 IMM; other bits read as 0.
  - `shadow`: the converted value waiting for commit.
  - `commit`: the value currently driven to the scanner.
- **Reset values:**
  - `raw`, `shadow` and `commit` = `RST_VAL`.
  - `ctrl` = 3'b001.
  - State = IDLE; `bus_ready` = 1; `data` = `RST_VAL`.
- **Write to `ADDR_DISP`:** merge `bus_wdata` into `raw` under `bus_wstrb`. The conversion input is the merged value.
  - BCD = 0: `shadow` <= merged value; go to PEND.
  - BCD = 1: start the conversion; go to CONV.
- **Write to `ADDR_CTRL`:** updates `ctrl` under `bus_wstrb[0]` only. It does not start a conversion.
- **Reads:** combinational and zero-wait.
  - `ADDR_DISP` returns `raw`.
  - `ADDR_CTRL` returns `{28'b0, pending, ctrl}`, where `pending` = (state != IDLE).
- **Unmapped addresses:** `bus_ready` = 1, `bus_rdata` = 0, writes ignored.
- **States:**
  - IDLE: waits for a `ADDR_DISP` write.
  - CONV: iterative double-dabble, one shift per cycle for 32 cycles, then writes `shadow` and moves to PEND.
  - PEND: waits for `frame_tick | IMM`, then sets `commit` <= `shadow` and returns to IDLE.
- **Overflow:** in BCD mode, if the merged value > 99_999_999, the conversion result is 32'hEEEE_EEEE. The full 32 cycles are still spent.
- **Output:** `data` = EN ? `commit` : 32'h0. `commit` is retained while EN = 0.
- **Handshake:** `bus_ready` = 0 only in CONV, and only for an access to `ADDR_DISP` or `ADDR_CTRL`. All other accesses are ready in every state.
- **Boundary cases:**
  - Write in PEND: `shadow` is replaced (hex) or CONV restarts (BCD). Latest write wins.
  - Write in PEND in the same cycle as `frame_tick`: the old `shadow` commits, and the new write is processed as above. The old value is never lost to a race.
  - `frame_tick` in IDLE or CONV: ignored.
  - `rst` mid-CONV or mid-PEND: returns to IDLE and all registers take their reset values. The partial result is discarded.

## Timing
- The write handshake completes in cycle N.
- **Hex mode:** `shadow` is valid after edge N; with IMM = 1, `data` changes after edge N+1.
- **BCD mode:** CONV occupies cycles N+1..N+32 (`bus_ready` low for register accesses). `shadow` is valid after edge N+32; with IMM = 1, `data` changes after edge N+33.
- **IMM = 0:** the commit happens at the edge of the first `frame_tick` cycle in PEND.
- `bus_rdata` reflects `raw` from cycle N+1.

## Configuration
- `SEG_BCD_EN` defined:
  - The CONV state and the converter are built.
  - `ctrl` bit1 is writable.
- `SEG_BCD_EN` undefined:
  - `ctrl` bit1 is read-as-zero and write-ignored.
  - There is no CONV state, and `bus_ready` is constant 1.
  - Every `ADDR_DISP` write goes directly to PEND.

## Structure
- **Package `seg_pkg`:**
  - Default address constants.
  - `ctrl` bit indices (EN/BCD/IMM).
  - State enum (IDLE/CONV/PEND).
  - `BCD_MAX` = 99_999_999.
  - Overflow pattern 32'hEEEE_EEEE.
  - Iteration count 32.
- **Sub-module `bcd_conv`:** iterative double-dabble with a `start`/`busy`/`done` pulse interface, 32-bit input and 32-bit output. Instantiated only under `SEG_BCD_EN`.

## Test plan
- Reset, then read both registers: `ADDR_CTRL` reads 0x1 and `ADDR_DISP` reads 0; `data` = 0.
- Hex mode, IMM = 1, write 0x1234_5678 with `bus_wstrb` = 4'b1111 at cycle N: `data` = 0x1234_5678 after edge N+1.
- Write 0xAB with `bus_wstrb` = 4'b0010 over 0x1234_5678: `raw` = 0x1234_AB78. With IMM = 0 and no `frame_tick`, `data` is unchanged and `pending` reads 1. After a `frame_tick`, `data` = 0x1234_AB78.
- BCD mode, IMM = 1, write 12_345_678: `bus_ready` is low for 32 cycles, then `data` = 0x1234_5678. A write of 100_000_000 gives 0xEEEE_EEEE.
- Write A in PEND, then write B in the same cycle as `frame_tick`: `data` = A immediately. After the next `frame_tick`, `data` = B.
- Assert `rst` in CONV cycle 10: state returns to IDLE, `data` = `RST_VAL`, `bus_ready` = 1, and no commit occurs afterwards. EN = 0 forces `data` to 0; EN = 1 restores it.
